// File: rtl/framebuffer_1bpp_pkg.sv
// Shared framebuffer definitions: geometry, read-mode encodings, RAM address
// width, FSM state encoding and the captured-coordinate payload.
// Ports: none (package).
package framebuffer_1bpp_pkg;

   localparam int unsigned FB_WIDTH         = 128;
   localparam int unsigned FB_HEIGHT        = 64;
   localparam int unsigned FB_BYTES_PER_ROW = FB_WIDTH / 8;
   localparam int unsigned FB_ADDR_W        = 10;
   localparam int unsigned COORD_W          = 8;
   // Row index is one bit wider than a coordinate so y+k never wraps.
   localparam int unsigned ROW_W            = COORD_W + 1;

   localparam logic FB_MODE_HORIZONTAL = 1'b0;
   localparam logic FB_MODE_COLUMN     = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_H,
      ST_RD_C,
      ST_RD_VALID,
      ST_WR_MOD,
      ST_CLEAR
   } fb_state_t;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } fb_coord_t;

endpackage

// File: rtl/fb_bram.sv
// Single-port byte RAM, 2^FB_ADDR_W x 8, synchronous read-first, one-cycle
// read latency. Written in the plain template block-RAM inference expects.
// Ports: clk; we (write enable); addr; din (write data); dout (read data,
//        valid the cycle after addr is presented).
module fb_bram
   import framebuffer_1bpp_pkg::*;
(
   input  logic                 clk,
   input  logic                 we,
   input  logic [FB_ADDR_W-1:0] addr,
   input  logic [7:0]           din,
   output logic [7:0]           dout
);

   localparam int unsigned DEPTH = 1 << FB_ADDR_W;

   logic [7:0] mem [0:DEPTH-1];

   // Contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= din;
      end
      dout <= mem[addr];
   end

endmodule

// File: rtl/framebuffer_1bpp.sv
// 1 bit-per-pixel framebuffer on one single-port RAM. Serves horizontal and
// column (page-format) byte reads, single-pixel read-modify-write updates and
// a bulk clear, all serialised by one FSM with priority clear > read > write.
// Ports: clk, reset_n (sync, active low);
//        w_xpos/w_ypos/w_pixel/w_we -> w_ready   pixel write handshake;
//        r_xpos/r_ypos/r_mode/r_re -> r_dout/r_data_valid   byte read;
//        clear -> busy   bulk clear.
module framebuffer_1bpp
   import framebuffer_1bpp_pkg::*;
#(
   parameter int unsigned WIDTH  = FB_WIDTH,
   parameter int unsigned HEIGHT = FB_HEIGHT
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [COORD_W-1:0] w_xpos,
   input  logic [COORD_W-1:0] w_ypos,
   input  logic               w_pixel,
   input  logic               w_we,
   output logic               w_ready,
   input  logic [COORD_W-1:0] r_xpos,
   input  logic [COORD_W-1:0] r_ypos,
   input  logic               r_mode,
   input  logic               r_re,
   output logic [7:0]         r_dout,
   output logic               r_data_valid,
   input  logic               clear,
   output logic               busy
);

   localparam int unsigned BYTES_PER_ROW = WIDTH / 8;
   localparam int unsigned NUM_BYTES     = (WIDTH * HEIGHT) / 8;
   localparam logic [ROW_W-1:0]     WIDTH_LIM  = ROW_W'(WIDTH);
   localparam logic [ROW_W-1:0]     HEIGHT_LIM = ROW_W'(HEIGHT);
   localparam logic [FB_ADDR_W-1:0] LAST_ADDR  = FB_ADDR_W'(NUM_BYTES - 1);

   fb_state_t            state, state_next;
   fb_coord_t            rd_cap, wr_cap;
   logic                 wr_pixel;
   logic [2:0]           col_k;
   logic [FB_ADDR_W-1:0] clr_addr;
   logic                 clear_pending;

   logic [FB_ADDR_W-1:0] ram_addr;
   logic                 ram_we;
   logic [7:0]           ram_din, ram_dout;

   logic [ROW_W-1:0]     rd_row, wr_row;
   logic [7:0]           merged;

   // Byte address of (row, x) with x already reduced to its byte column.
   function automatic logic [FB_ADDR_W-1:0] byte_addr(input logic [ROW_W-1:0] row,
                                                      input logic [4:0]       xbyte);
      return FB_ADDR_W'(32'(row) * BYTES_PER_ROW + 32'(xbyte));
   endfunction

   function automatic logic in_range(input logic [COORD_W-1:0] x,
                                     input logic [ROW_W-1:0]   row);
      return ({1'b0, x} < WIDTH_LIM) && (row < HEIGHT_LIM);
   endfunction

   assign rd_row  = {1'b0, rd_cap.y} + ROW_W'(col_k);
   assign wr_row  = {1'b0, wr_cap.y};
   assign w_ready = reset_n && (state == ST_IDLE) && !clear && !clear_pending && !r_re;

   // Pixel x lives at bit 7-x[2:0], i.e. bit ~x[2:0] (MSB = leftmost).
   always_comb begin
      merged                  = ram_dout;
      merged[~wr_cap.x[2:0]]  = wr_pixel;
   end

   fb_bram u_bram (
      .clk  (clk),
      .we   (ram_we && reset_n),
      .addr (ram_addr),
      .din  (ram_din),
      .dout (ram_dout)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and RAM port control. The first RAM read of every access is
   // issued from IDLE so data returns in the first cycle of the next state.
   always_comb begin
      state_next = state;
      ram_addr   = '0;
      ram_we     = 1'b0;
      ram_din    = '0;
      case (state)
         ST_IDLE: begin
            if (clear || clear_pending) begin
               state_next = ST_CLEAR;
            end else if (r_re) begin
               case (r_mode)
                  FB_MODE_COLUMN:     state_next = ST_RD_C;
                  FB_MODE_HORIZONTAL: state_next = ST_RD_H;
               endcase
               ram_addr = byte_addr({1'b0, r_ypos}, r_xpos[7:3]);
            end else if (w_we) begin
               state_next = ST_WR_MOD;
               ram_addr   = byte_addr({1'b0, w_ypos}, w_xpos[7:3]);
            end
         end
         ST_RD_H: begin
            state_next = r_re ? ST_RD_VALID : ST_IDLE;
         end
         ST_RD_C: begin
            // Prefetch the next row while the current one is being captured.
            ram_addr = byte_addr(rd_row + ROW_W'(1), rd_cap.x[7:3]);
            if (!r_re) begin
               state_next = ST_IDLE;
            end else if (col_k == 3'd7) begin
               state_next = ST_RD_VALID;
            end
         end
         ST_RD_VALID: begin
            if (!r_re) begin
               state_next = ST_IDLE;
            end
         end
         ST_WR_MOD: begin
            ram_addr   = byte_addr(wr_row, wr_cap.x[7:3]);
            ram_we     = in_range(wr_cap.x, wr_row);
            ram_din    = merged;
            state_next = ST_IDLE;
         end
         ST_CLEAR: begin
            ram_addr = clr_addr;
            ram_we   = 1'b1;
            if (clr_addr == LAST_ADDR) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Request capture, read data assembly, clear sequencing and status flags.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_dout        <= '0;
         r_data_valid  <= 1'b0;
         busy          <= 1'b0;
         clear_pending <= 1'b0;
         clr_addr      <= '0;
         col_k         <= '0;
         rd_cap        <= '0;
         wr_cap        <= '0;
         wr_pixel      <= 1'b0;
      end else begin
         r_data_valid <= (state_next == ST_RD_VALID);
         busy         <= (state_next == ST_CLEAR);

         // IDLE always services a pending clear, so it can be dropped there.
         if (state == ST_IDLE) begin
            clear_pending <= 1'b0;
         end else if (clear && (state != ST_CLEAR)) begin
            clear_pending <= 1'b1;
         end

         clr_addr <= (state == ST_CLEAR) ? clr_addr + FB_ADDR_W'(1) : '0;

         case (state)
            ST_IDLE: begin
               if ((state_next == ST_RD_H) || (state_next == ST_RD_C)) begin
                  rd_cap.x <= r_xpos;
                  rd_cap.y <= r_ypos;
                  col_k    <= '0;
               end
               if (state_next == ST_WR_MOD) begin
                  wr_cap.x <= w_xpos;
                  wr_cap.y <= w_ypos;
                  wr_pixel <= w_pixel;
               end
            end
            ST_RD_H: begin
               if (r_re) begin
                  r_dout <= in_range(rd_cap.x, rd_row) ? ram_dout : 8'h00;
               end
            end
            ST_RD_C: begin
               if (r_re) begin
                  r_dout[col_k] <= in_range(rd_cap.x, rd_row) ? ram_dout[~rd_cap.x[2:0]] : 1'b0;
                  col_k         <= col_k + 3'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_framebuffer_1bpp.sv
// Directed self-checking bench for framebuffer_1bpp: reset values, clear
// length, horizontal/column reads and their latencies, bit mapping, range
// masking, clear arbitration against reads, reset during a read, read abort.
module tb_framebuffer_1bpp;
   import framebuffer_1bpp_pkg::*;

   localparam int unsigned H_LAT = 1;   // edges after acceptance until valid
   localparam int unsigned C_LAT = 8;
   localparam int unsigned X_OOR = FB_BYTES_PER_ROW * 8 + 2;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] w_xpos = '0, w_ypos = '0;
   logic       w_pixel = 1'b0, w_we = 1'b0;
   logic       w_ready;
   logic [7:0] r_xpos = '0, r_ypos = '0;
   logic       r_mode = 1'b0, r_re = 1'b0;
   logic [7:0] r_dout;
   logic       r_data_valid;
   logic       clear = 1'b0;
   logic       busy;

   int vectors = 0;
   int miscompares = 0;

   framebuffer_1bpp dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .w_xpos       (w_xpos),
      .w_ypos       (w_ypos),
      .w_pixel      (w_pixel),
      .w_we         (w_we),
      .w_ready      (w_ready),
      .r_xpos       (r_xpos),
      .r_ypos       (r_ypos),
      .r_mode       (r_mode),
      .r_re         (r_re),
      .r_dout       (r_dout),
      .r_data_valid (r_data_valid),
      .clear        (clear),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic write_px(input string tag, input int x, input int y, input logic p);
      chk({tag, "_ready"}, 32'(w_ready), 1);
      w_xpos  = 8'(x);
      w_ypos  = 8'(y);
      w_pixel = p;
      w_we    = 1'b1;
      tick();
      w_we = 1'b0;
      chk({tag, "_ready_low"}, 32'(w_ready), 0);
      tick();
   endtask

   task automatic rd_start(input int x, input int y, input logic mode);
      r_xpos = 8'(x);
      r_ypos = 8'(y);
      r_mode = mode;
      r_re   = 1'b1;
   endtask

   // Counts edges until valid, checks data, hold behaviour and release.
   task automatic rd_finish(input string tag, input int exp_lat, input logic [7:0] exp_data);
      int n;
      n = 0;
      while (!r_data_valid && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
      chk({tag, "_data"}, 32'(r_dout), 32'(exp_data));
      tick();
      chk({tag, "_hold_valid"}, 32'(r_data_valid), 1);
      chk({tag, "_hold_data"}, 32'(r_dout), 32'(exp_data));
      r_re = 1'b0;
      tick();
      chk({tag, "_valid_drop"}, 32'(r_data_valid), 0);
   endtask

   task automatic rd(input string tag, input int x, input int y, input logic mode,
                     input int exp_lat, input logic [7:0] exp_data);
      rd_start(x, y, mode);
      tick();
      rd_finish(tag, exp_lat, exp_data);
   endtask

   // Called with busy just observed high; counts busy cycles.
   task automatic wait_clear(input string tag);
      int n;
      int bad;
      n = 0;
      bad = 0;
      while (busy && n < 2000) begin
         n++;
         if (w_ready !== 1'b0) bad++;
         tick();
      end
      chk({tag, "_busy_len"}, 32'(n), 1024);
      chk({tag, "_wready_low"}, 32'(bad), 0);
   endtask

   initial begin
      int vc;

      // Reset state
      tick();
      tick();
      chk("rst_valid", 32'(r_data_valid), 0);
      chk("rst_dout", 32'(r_dout), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_wready", 32'(w_ready), 0);
      reset_n = 1'b1;
      tick();
      chk("idle_wready", 32'(w_ready), 1);

      // 1: clear, then column read of a blank column
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("t1_busy", 32'(busy), 1);
      wait_clear("t1");
      rd("t1_col00", 0, 0, FB_MODE_COLUMN, C_LAT, 8'h00);

      // 2: bit mapping in both read shapes
      write_px("t2_w00", 0, 0, 1'b1);
      write_px("t2_w07", 0, 7, 1'b1);
      write_px("t2_w53", 5, 3, 1'b1);
      rd("t2_col00", 0, 0, FB_MODE_COLUMN, C_LAT, 8'h81);
      rd("t2_h03", 0, 3, FB_MODE_HORIZONTAL, H_LAT, 8'h04);

      // 3: bottom-right corner and out-of-range x
      write_px("t3_wcorner", 127, 63, 1'b1);
      rd("t3_h120_63", 120, 63, FB_MODE_HORIZONTAL, H_LAT, 8'h01);
      rd("t3_h00", 0, 0, FB_MODE_HORIZONTAL, H_LAT, 8'h80);
      rd("t3_hoor", X_OOR, 63, FB_MODE_HORIZONTAL, H_LAT, 8'h00);
      write_px("t3_woor", 200, 5, 1'b1);
      rd("t3_h72_6", 72, 6, FB_MODE_HORIZONTAL, H_LAT, 8'h00);

      // 4: column read running past the bottom edge
      write_px("t4_w10_0", 10, 0, 1'b1);
      write_px("t4_w10_1", 10, 1, 1'b1);
      write_px("t4_w10_60", 10, 60, 1'b1);
      write_px("t4_w10_63", 10, 63, 1'b1);
      rd("t4_col10_60", 10, 60, FB_MODE_COLUMN, C_LAT, 8'h09);
      rd("t4_col10_0", 10, 0, FB_MODE_COLUMN, C_LAT, 8'h03);

      // Clear raised during a read is held until the read completes
      rd_start(0, 0, FB_MODE_HORIZONTAL);
      tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("pend_valid", 32'(r_data_valid), 1);
      chk("pend_data", 32'(r_dout), 32'h80);
      chk("pend_busy_low", 32'(busy), 0);
      r_re = 1'b0;
      tick();
      chk("pend_wready", 32'(w_ready), 0);
      chk("pend_busy_idle", 32'(busy), 0);
      tick();
      chk("pend_busy", 32'(busy), 1);
      wait_clear("pend");
      rd("pend_h00", 0, 0, FB_MODE_HORIZONTAL, H_LAT, 8'h00);

      // 5: clear and read in the same cycle; read waits behind the clear
      write_px("t5_w00", 0, 0, 1'b1);
      write_px("t5_w32", 3, 2, 1'b1);
      clear = 1'b1;
      rd_start(0, 0, FB_MODE_COLUMN);
      tick();
      clear = 1'b0;
      chk("t5_busy", 32'(busy), 1);
      wait_clear("t5");
      rd_finish("t5_col00", 1 + C_LAT, 8'h00);

      // 6a: reset in the middle of a column read
      vc = 0;
      rd_start(0, 0, FB_MODE_COLUMN);
      for (int i = 0; i < 4; i++) begin
         tick();
         vc += int'(r_data_valid);
      end
      reset_n = 1'b0;
      chk("t6a_wready_rst", 32'(w_ready), 0);
      tick();
      vc += int'(r_data_valid);
      tick();
      vc += int'(r_data_valid);
      chk("t6a_wready_rst2", 32'(w_ready), 0);
      chk("t6a_dout_rst", 32'(r_dout), 0);
      reset_n = 1'b1;
      r_re = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         vc += int'(r_data_valid);
      end
      chk("t6a_no_valid", 32'(vc), 0);
      chk("t6a_wready_idle", 32'(w_ready), 1);

      // 6b: read abort by dropping r_re mid column read
      vc = 0;
      rd_start(0, 0, FB_MODE_COLUMN);
      for (int i = 0; i < 3; i++) begin
         tick();
         vc += int'(r_data_valid);
      end
      r_re = 1'b0;
      tick();
      vc += int'(r_data_valid);
      chk("t6b_wready", 32'(w_ready), 1);
      for (int i = 0; i < 10; i++) begin
         tick();
         vc += int'(r_data_valid);
      end
      chk("t6b_no_valid", 32'(vc), 0);
      write_px("t6b_w53", 5, 3, 1'b1);
      rd("t6b_h03", 0, 3, FB_MODE_HORIZONTAL, H_LAT, 8'h04);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
